// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, FSM state encodings and helper functions for the
// load/store unit. The optional misalignment trap is controlled by the
// LSU_MISALIGN_TRAP_EN macro. That macro is used in lsu.sv; this package
// does not depend on it.
package lsu_pkg;

    // Access size as encoded on req_size
    typedef enum logic [1:0] {
        SIZE_B   = 2'b00,
        SIZE_H   = 2'b01,
        SIZE_W   = 2'b10,
        SIZE_RSV = 2'b11
    } lsu_size_e;

    // FSM state encodings
    localparam logic [1:0] IDLE      = 2'b00;
    localparam logic [1:0] LOAD_WAIT = 2'b01;
    localparam logic [1:0] RESP      = 2'b10;

    // Byte-lane enables for a store of the given size at the given offset.
    // Half uses addr[1] only. Word and reserved sizes ignore the offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001 << off;
            SIZE_H:  mask = off[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // True for accesses that the trap build rejects.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the raw memory word so that the addressed byte or
// half lands in bit 0, then applies sign or zero extension. The logic is
// purely combinational.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [1:0]  shamt_s;
    logic [31:0] shifted_s;

    // Select the byte shift. Half uses addr[1] only, and word is never shifted.
    always_comb begin
        shamt_s = 2'b00;
        case (size)
            SIZE_B:  shamt_s = off;
            SIZE_H:  shamt_s = {off[1], 1'b0};
            default: shamt_s = 2'b00;
        endcase
        shifted_s = rdata >> {shamt_s, 3'b000};
    end

    // Extend from bit 7 or bit 15. Word and reserved sizes pass through.
    always_comb begin
        result = shifted_s;
        case (size)
            SIZE_B: begin
                if (uns) begin
                    result = {24'h000000, shifted_s[7:0]};
                end else begin
                    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SIZE_H: begin
                if (uns) begin
                    result = {16'h0000, shifted_s[15:0]};
                end else begin
                    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            default: result = shifted_s;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: a single-outstanding load/store unit in front of the data memory.
// It drives the memory strobes combinationally in the accept cycle. It
// returns aligned and extended load data, or zero for stores, through a
// valid/ready response port.
// Optional feature: defining LSU_MISALIGN_TRAP_EN turns misaligned accesses
// and the reserved size into error responses that never touch memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             mem_read_ready,
    output logic             mem_write_ready,
    output logic [31:2]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic [3:0]       mem_write_byte,
    input  logic [31:0]      mem_read_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    logic [1:0]       state_q,    state_d;
    logic [1:0]       off_q,      off_d;
    logic [1:0]       size_q,     size_d;
    logic             uns_q,      uns_d;
    logic [TAG_W-1:0] tag_q,      tag_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q,  rsp_err_d;

    logic             accept_s;
    logic             err_s;
    logic [31:0]      wdata_rep_s;
    logic [31:0]      align_s;

    lsu_load_align u_align (
        .rdata  (mem_read_data),
        .off    (off_q),
        .size   (size_q),
        .uns    (uns_q),
        .result (align_s)
    );

    // Accept qualification, error detection and store-data lane replication
    always_comb begin
        req_ready = (state_q == IDLE) && rst_n;
        accept_s  = req_valid && req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
        err_s     = misaligned(req_size, req_addr[1:0]);
`else
        err_s     = 1'b0;
`endif
        case (req_size)
            SIZE_B:  wdata_rep_s = {4{req_wdata[7:0]}};
            SIZE_H:  wdata_rep_s = {2{req_wdata[15:0]}};
            default: wdata_rep_s = req_wdata;
        endcase
    end

    // Memory strobes exist only in the accept cycle of a non-error request
    always_comb begin
        mem_write_ready = accept_s && req_we && !err_s;
        mem_read_ready  = accept_s && !req_we && !err_s;
        mem_address     = rst_n ? req_addr[31:2] : 30'h0;
        if (mem_write_ready) begin
            mem_write_byte = lane_mask(req_size, req_addr[1:0]);
            mem_write_data = wdata_rep_s;
        end else begin
            mem_write_byte = 4'b0000;
            mem_write_data = 32'h0000_0000;
        end
    end

    // FSM next state and response payload capture
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    tag_d = req_tag;
                    if (err_s) begin
                        rsp_data_d = req_addr;
                        rsp_err_d  = 1'b1;
                        state_d    = RESP;
                    end else if (req_we) begin
                        rsp_data_d = 32'h0000_0000;
                        rsp_err_d  = 1'b0;
                        state_d    = RESP;
                    end else begin
                        off_d     = req_addr[1:0];
                        size_d    = req_size;
                        uns_d     = req_unsigned;
                        rsp_err_d = 1'b0;
                        state_d   = LOAD_WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: begin
                rsp_data_d = align_s;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            tag_q      <= '0;
            rsp_data_q <= 32'h0000_0000;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Response port. It is forced to zero while reset is held.
    always_comb begin
        rsp_valid = (state_q == RESP) && rst_n;
        if (rst_n) begin
            rsp_data = rsp_data_q;
            rsp_tag  = tag_q;
            rsp_err  = rsp_err_q;
        end else begin
            rsp_data = 32'h0000_0000;
            rsp_tag  = '0;
            rsp_err  = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for lsu with a one-cycle-latency memory model.
module tb_lsu;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]       req_size;
    logic [31:0]      req_addr, req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             mem_read_ready, mem_write_ready;
    logic [31:2]      mem_address;
    logic [31:0]      mem_write_data;
    logic [3:0]       mem_write_byte;
    logic [31:0]      mem_read_data;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    always #5 clk = ~clk;

    lsu #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_byte(mem_write_byte), .mem_read_data(mem_read_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // Memory model: byte-lane writes and one-cycle registered reads
    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_write_ready) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_byte[i]) mem[mem_address[9:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
        if (mem_read_ready) mem_read_data <= mem[mem_address[9:2]];
    end

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One request: check the accept-cycle strobes, push the expected response,
    // wait for rsp_valid, pop and compare, optionally stall, then check the release.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                          input logic exp_err, input logic [3:0] exp_lanes,
                          input logic [31:0] exp_wdata, input int exp_lat, input int hold);
        rsp_t r;
        rsp_t got;
        int   lat;
        @(negedge clk);
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        #1;
        check("req_ready", 32'(req_ready), 32'd1);
        check("mem_write_ready", 32'(mem_write_ready), 32'(we && !exp_err));
        check("mem_read_ready", 32'(mem_read_ready), 32'(!we && !exp_err));
        check("mem_write_byte", 32'(mem_write_byte), 32'(exp_lanes));
        check("mem_write_data", mem_write_data, exp_wdata);
        check("mem_address", {2'b00, mem_address}, {2'b00, addr[31:2]});
        r = '{data: exp_data, tag: tag, err: exp_err};
        sb_q.push_back(r);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        if (rsp_valid === 1'b1 && sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check("rsp_data", rsp_data, got.data);
            check("rsp_tag", 32'(rsp_tag), 32'(got.tag));
            check("rsp_err", 32'(rsp_err), 32'(got.err));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_data", rsp_data, r.data);
            check("hold_tag", 32'(rsp_tag), 32'(r.tag));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0100; req_wdata = 32'h0; req_tag = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_read_ready", 32'(mem_read_ready), 32'd0);
        check("rst_mem_write_ready", 32'(mem_write_ready), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_mem_address", {2'b00, mem_address}, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);

        preload(8'h40, 32'h1122_3344);
        // SW, SB, then LW merging the stored byte
        do_req(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 5'd1, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 1, 0);
        check("mem_sw", mem[8'h41], 32'hDEAD_BEEF);
        do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 5'd2, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 1, 0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd3, 32'hA522_3344, 1'b0, 4'b0000, 32'h0, 2, 0);

        // LB and LBU
        preload(8'h40, 32'h0080_FF00);
        do_req(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 5'd4, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0, 2, 0);
        do_req(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 5'd5, 32'h0000_0080, 1'b0, 4'b0000, 32'h0, 2, 0);

        // LH with a 3-cycle consumer stall, then LHU
        preload(8'h40, 32'h8001_1234);
        do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd6, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0, 2, 3);
        do_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 5'd7, 32'h0000_1234, 1'b0, 4'b0000, 32'h0, 2, 0);

        // SH to the upper half
        do_req(1'b1, 2'b01, 1'b0, 32'h106, 32'h0000_CAFE, 5'd10, 32'h0, 1'b0, 4'b1100, 32'hCAFE_CAFE, 1, 0);
        check("mem_sh", mem[8'h41], 32'hCAFE_BEEF);

        // Misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd8, 32'h0000_0101, 1'b1, 4'b0000, 32'h0, 1, 0);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd8, 32'h8001_1234, 1'b0, 4'b0000, 32'h0, 2, 0);
`endif

        // Reset asserted during LOAD_WAIT
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h104; req_tag = 5'd9; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_mem_read_ready", 32'(mem_read_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_rel_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rel_data", rsp_data, 32'h0);
        check("midrst_rel_tag", 32'(rsp_tag), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end

        // Recovery: LBU of byte 0 of 0x80011234
        do_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h0, 5'd11, 32'h0000_0034, 1'b0, 4'b0000, 32'h0, 2, 0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data-side `Memory` instance in the 3-stage RISC-V core. It accepts one load or store request at a time from the execute stage and drives the memory's word address, read/write strobes, byte lanes and lane-replicated write data. It then captures the one-cycle-latency read word and returns an aligned, sign- or zero-extended result through a valid/ready response port to writeback.

## Interface
Parameters:
- `TAG_W`, 5: width of the destination-register tag carried from request to response.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: load zero-extends (LBU/LHU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `req_tag` in TAG_W: returned unchanged on response.
- `mem_read_ready` out 1: memory read strobe.
- `mem_write_ready` out 1: memory write strobe.
- `mem_address` out [31:2]: word address; drives both memory read and write address.
- `mem_write_data` out 32: lane-replicated store data.
- `mem_write_byte` out 4: byte-lane enables.
- `mem_read_data` in 32: memory read word, valid one cycle after the read strobe.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_data` out 32: load result, or 0 for stores.
- `rsp_tag` out TAG_W: tag of the completed request.
- `rsp_err` out 1: misaligned or reserved-size access.

## Operation
- FSM states: IDLE, LOAD_WAIT, RESP. `req_ready = (state==IDLE) && rst_n`.
- Accept is `req_valid && req_ready`. Memory strobes are combinational from the accept cycle only; otherwise they are 0.
- **Store accept:**
  - `mem_write_ready=1`.
  - Byte: lanes `1<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - Half: lanes `addr[1] ? 1100 : 0011`, data `{2{wdata[15:0]}}`.
  - Word or reserved: lanes 1111, data `wdata`.
  - Next state RESP with `rsp_data=0`.
- **Load accept:** `mem_read_ready=1`, `mem_write_byte=0`. Next state LOAD_WAIT; latch `addr[1:0]`, size, unsigned and tag.
- **LOAD_WAIT:**
  - Shift `mem_read_data` right by `8*addr[1:0]`.
  - Extend from bit 7 (byte) or bit 15 (half); use zero extension when unsigned. Word passes through unchanged.
  - Register the result into `rsp_data`, then go to RESP.
- **RESP:** `rsp_valid=1`; data, tag and error are held stable. On `rsp_ready` go to IDLE. No new request is accepted in the same cycle.
- Every accepted request yields exactly one response, in order. Only one request can be outstanding.
- **Reset** (any state, including mid-op):
  - State returns to IDLE.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_err=0`.
  - Pending load data is discarded.
  - A store strobed before the reset edge remains committed in memory.

## Timing
- Store: accept in cycle 0, memory written at edge 0→1, `rsp_valid` in cycle 1.
- Load: accept in cycle 0, memory read at edge 0→1, data captured at edge 1→2, `rsp_valid` in cycle 2.
- With `rsp_ready` held high, throughput is one store per 2 cycles and one load per 3 cycles.
- `rsp_valid` falls the cycle after the handshake. `req_ready` rises in that same cycle.
- All outputs are 0 during reset. Memory strobes cannot assert while `rst_n=0`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Half with `addr[0]=1`, word with `addr[1:0]!=0`, and size 11 are errors.
  - On an error accept, no memory strobe is driven. Next state is RESP with `rsp_err=1` and `rsp_data=req_addr`.
  - Error latency is 1 cycle.
- **Undefined:**
  - Half uses `addr[1]` only; word ignores `addr[1:0]`; size 11 is treated as word.
  - `rsp_err` is tied to 0.

## Structure
- `lsu_pkg`:
  - size enum: SIZE_B, SIZE_H, SIZE_W, SIZE_RSV.
  - state enum: IDLE, LOAD_WAIT, RESP.
  - function returning the lane mask from size and `addr[1:0]`.
- Sub-module `lsu_load_align`: combinational shift and extend from `mem_read_data`, offset, size and unsigned to 32-bit result. Instantiated once in LOAD_WAIT.

## Test plan
- SW: addr 0x104, wdata 0xDEADBEEF → `mem_address`=0x41, lanes 1111, data 0xDEADBEEF, `rsp_valid` in cycle 1 with data 0.
- SB: addr 0x103, wdata 0x000000A5 → lanes 1000, data 0xA5A5A5A5. A following LW at 0x100 over memory word 0x11223344 returns 0xA5223344.
- LB and LBU: addr 0x102 over word 0x0080FF00 → 0xFFFFFF80 and 0x00000080, each with `rsp_valid` in cycle 2 and the tag echoed.
- LH: addr 0x102 over word 0x8001_1234 → 0xFFFF8001. With `rsp_ready=0` for 3 cycles, data and tag are held and `req_ready` stays 0.
- Misaligned LW at 0x101:
  - With macro: no strobes, `rsp_err=1`, `rsp_data`=0x101.
  - Without macro: word at 0x100 returned, `rsp_err=0`.
- `rst_n` low during LOAD_WAIT → next cycle IDLE, `rsp_valid=0`, `req_ready=1` after release, and no stale response is delivered.
